decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter BYPASS, default 1, meaning same-cycle writeback-to-read forwarding enabled.
REQ-002 SHALL have port clock  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports in_valid in 1, in_ready out 1, in_instr in 32, in_pc in 32: fetch-side handshake, instruction word and its PC.
REQ-005 SHALL have ports wb_en in 1, wb_rd in 5, wb_data in 32: register writeback.
REQ-006 SHALL have port flush  in  1  synchronous pipeline kill.
REQ-007 SHALL have ports out_valid out 1 and out_ready in 1: execute-side handshake.
REQ-008 SHALL have outputs out_pc 32, out_data1 32, out_data2 32, out_alu_control 5, out_rd 5, out_reg_write 1, out_is_branch 1, out_branch_offset 32, out_illegal 1: ALU operands and control, all registered.

Function
REQ-009 SHALL hold a 32x32 register file; x0 reads 0 always; writes to x0 ignored.
REQ-010 SHALL write wb_data to wb_rd on clock edge when wb_en=1 and wb_rd!=0.
REQ-011 SHALL, with BYPASS=1, return wb_data for a read of rs1/rs2 equal to a same-cycle nonzero wb_rd with wb_en=1; with BYPASS=0, return the stored value.
REQ-012 SHALL decode opcode 0110011 (R-type): data1=rs1, data2=rs2; {funct7,funct3} selects ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND ALU control codes.
REQ-013 SHALL decode opcode 0010011 (I-type): data1=rs1, data2=sign-extended imm[11:0]; funct3 001 -> SLLI code, 101 -> SRLI_SRAI code with data2={20'b0, instr[31:20]} so bits [11:5] carry funct7 and [4:0] the shamt.
REQ-014 SHALL decode LUI (0110111): data1=0, data2={instr[31:12],12'b0}, LUI code; AUIPC (0010111): data2 as LUI, AUIPC code, out_pc carries in_pc.
REQ-015 SHALL decode branch (1100011): data1=rs1, data2=rs2; funct3 000/001/100/101/110/111 -> B_EQUAL/B_NOT_EQ/B_LT/B_GE/B_LTU/B_GEU; out_is_branch=1; out_branch_offset=sign-extended B-immediate.
REQ-016 SHALL set out_reg_write=1 only for R, I, LUI, AUIPC with rd!=0; 0 for branches and illegal.
REQ-017 SHALL treat any other opcode, or an undefined funct combination, as illegal: out_illegal=1, out_alu_control=ADD code, out_reg_write=0, out_is_branch=0.
REQ-018 SHALL drive in_ready = !flush && (!out_valid || out_ready), combinationally.
REQ-019 SHALL capture the decode into the output register when in_valid && in_ready; latency 1 cycle; out_valid=1 next cycle.
REQ-020 SHALL clear out_valid when out_ready=1 and no new capture occurs that cycle.
REQ-021 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on flush=1, clear out_valid at the next edge and drop the presented instruction; flush overrides capture and out_ready.
REQ-023 SHALL perform register-file writeback independent of handshake, stall and flush.

Reset
REQ-024 SHALL, while reset_n=0, asynchronously clear out_valid and all out_* to 0 and all registers to 0; in_ready=1 after release.
REQ-025 SHALL, on reset mid-transfer, discard the held instruction; no output reappears after release.

Verification
REQ-026 Reset release, then ADD x3,x1,x2 -> out_data1=0, out_data2=0, out_rd=3, out_reg_write=1.
REQ-027 ADDI x1,x0,5 (0x00500093) accepted -> next cycle out_valid=1, ADD code, data1=0, data2=5, out_rd=1, out_reg_write=1.
REQ-028 wb_en=1, wb_rd=1, wb_data=0x00001234 same cycle as ADD x3,x1,x1 (0x001081B3) -> data1=data2=0x00001234; with BYPASS=0 -> both 0.
REQ-029 BEQ x1,x2,-8 (0xFE208CE3) -> B_EQUAL code, out_is_branch=1, out_branch_offset=0xFFFFFFF8, out_reg_write=0.
REQ-030 out_valid=1, out_ready=0 for 2 cycles, in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> new instruction captured next cycle.
REQ-031 flush=1 with out_valid=1, in_valid=1 -> in_ready=0, next cycle out_valid=0; opcode 0000000 -> out_illegal=1, out_reg_write=0.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage: 32x32 register file with optional writeback forwarding,
// RV32I subset decoder, and a one-deep registered output with valid/ready handshake.
module decode_stage #(
  parameter int BYPASS = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_data1,
  output logic [31:0] out_data2,
  output logic [4:0]  out_alu_control,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_is_branch,
  output logic [31:0] out_branch_offset,
  output logic        out_illegal
);

  localparam logic [4:0] ALU_ADD       = 5'd0;
  localparam logic [4:0] ALU_SUB       = 5'd1;
  localparam logic [4:0] ALU_SLL       = 5'd2;
  localparam logic [4:0] ALU_SLT       = 5'd3;
  localparam logic [4:0] ALU_SLTU      = 5'd4;
  localparam logic [4:0] ALU_XOR       = 5'd5;
  localparam logic [4:0] ALU_SRL       = 5'd6;
  localparam logic [4:0] ALU_SRA       = 5'd7;
  localparam logic [4:0] ALU_OR        = 5'd8;
  localparam logic [4:0] ALU_AND       = 5'd9;
  localparam logic [4:0] ALU_SLLI      = 5'd10;
  localparam logic [4:0] ALU_SRLI_SRAI = 5'd11;
  localparam logic [4:0] ALU_LUI       = 5'd12;
  localparam logic [4:0] ALU_AUIPC     = 5'd13;
  localparam logic [4:0] ALU_B_EQUAL   = 5'd14;
  localparam logic [4:0] ALU_B_NOT_EQ  = 5'd15;
  localparam logic [4:0] ALU_B_LT      = 5'd16;
  localparam logic [4:0] ALU_B_GE      = 5'd17;
  localparam logic [4:0] ALU_B_LTU     = 5'd18;
  localparam logic [4:0] ALU_B_GEU     = 5'd19;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_data1_q, out_data1_d;
  logic [31:0] out_data2_q, out_data2_d;
  logic [4:0]  out_alu_control_q, out_alu_control_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_reg_write_q, out_reg_write_d;
  logic        out_is_branch_q, out_is_branch_d;
  logic [31:0] out_branch_offset_q, out_branch_offset_d;
  logic        out_illegal_q, out_illegal_d;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_u, imm_b;
  logic [31:0] rs1_val, rs2_val;
  logic        wb_hit;
  logic        capture;

  logic [31:0] dec_data1, dec_data2, dec_offset;
  logic [4:0]  dec_alu, dec_rd;
  logic        dec_writes_rd, dec_branch, dec_illegal;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_b  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};

  assign wb_hit = wb_en && (wb_rd != 5'd0);

  // Forwarding only applies to a live writeback; x0 is never forwarded.
  always_comb begin
    rs1_val = rf_q[rs1];
    rs2_val = rf_q[rs2];
    if (BYPASS != 0 && wb_hit && wb_rd == rs1) rs1_val = wb_data;
    if (BYPASS != 0 && wb_hit && wb_rd == rs2) rs2_val = wb_data;
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_hit) rf_d[wb_rd] = wb_data;
  end

  always_comb begin
    dec_data1     = '0;
    dec_data2     = '0;
    dec_offset    = '0;
    dec_alu       = ALU_ADD;
    dec_rd        = '0;
    dec_writes_rd = 1'b0;
    dec_branch    = 1'b0;
    dec_illegal   = 1'b0;
    case (opcode)
      OP_R: begin
        dec_data1     = rs1_val;
        dec_data2     = rs2_val;
        dec_rd        = rd;
        dec_writes_rd = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: dec_alu = ALU_ADD;
          10'b0100000_000: dec_alu = ALU_SUB;
          10'b0000000_001: dec_alu = ALU_SLL;
          10'b0000000_010: dec_alu = ALU_SLT;
          10'b0000000_011: dec_alu = ALU_SLTU;
          10'b0000000_100: dec_alu = ALU_XOR;
          10'b0000000_101: dec_alu = ALU_SRL;
          10'b0100000_101: dec_alu = ALU_SRA;
          10'b0000000_110: dec_alu = ALU_OR;
          10'b0000000_111: dec_alu = ALU_AND;
          default:         dec_illegal = 1'b1;
        endcase
      end
      OP_I: begin
        dec_data1     = rs1_val;
        dec_data2     = imm_i;
        dec_rd        = rd;
        dec_writes_rd = 1'b1;
        case (funct3)
          3'b000: dec_alu = ALU_ADD;
          3'b010: dec_alu = ALU_SLT;
          3'b011: dec_alu = ALU_SLTU;
          3'b100: dec_alu = ALU_XOR;
          3'b110: dec_alu = ALU_OR;
          3'b111: dec_alu = ALU_AND;
          3'b001: begin
            dec_alu = ALU_SLLI;
            if (funct7 != 7'b0000000) dec_illegal = 1'b1;
          end
          default: begin
            // funct7 rides along in data2[11:5] so execute can pick SRL vs SRA
            dec_alu   = ALU_SRLI_SRAI;
            dec_data2 = {20'b0, in_instr[31:20]};
            if (funct7 != 7'b0000000 && funct7 != 7'b0100000) dec_illegal = 1'b1;
          end
        endcase
      end
      OP_LUI: begin
        dec_data2     = imm_u;
        dec_alu       = ALU_LUI;
        dec_rd        = rd;
        dec_writes_rd = 1'b1;
      end
      OP_AUIPC: begin
        dec_data2     = imm_u;
        dec_alu       = ALU_AUIPC;
        dec_rd        = rd;
        dec_writes_rd = 1'b1;
      end
      OP_BRANCH: begin
        dec_data1  = rs1_val;
        dec_data2  = rs2_val;
        dec_branch = 1'b1;
        dec_offset = imm_b;
        case (funct3)
          3'b000:  dec_alu = ALU_B_EQUAL;
          3'b001:  dec_alu = ALU_B_NOT_EQ;
          3'b100:  dec_alu = ALU_B_LT;
          3'b101:  dec_alu = ALU_B_GE;
          3'b110:  dec_alu = ALU_B_LTU;
          3'b111:  dec_alu = ALU_B_GEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_data1     = '0;
      dec_data2     = '0;
      dec_offset    = '0;
      dec_alu       = ALU_ADD;
      dec_rd        = '0;
      dec_writes_rd = 1'b0;
      dec_branch    = 1'b0;
    end
  end

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign capture  = in_valid && in_ready;

  always_comb begin
    out_valid_d         = out_valid_q;
    out_pc_d            = out_pc_q;
    out_data1_d         = out_data1_q;
    out_data2_d         = out_data2_q;
    out_alu_control_d   = out_alu_control_q;
    out_rd_d            = out_rd_q;
    out_reg_write_d     = out_reg_write_q;
    out_is_branch_d     = out_is_branch_q;
    out_branch_offset_d = out_branch_offset_q;
    out_illegal_d       = out_illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d         = 1'b1;
      out_pc_d            = in_pc;
      out_data1_d         = dec_data1;
      out_data2_d         = dec_data2;
      out_alu_control_d   = dec_alu;
      out_rd_d            = dec_rd;
      out_reg_write_d     = dec_writes_rd && (rd != 5'd0);
      out_is_branch_d     = dec_branch;
      out_branch_offset_d = dec_offset;
      out_illegal_d       = dec_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_q                <= '{default: '0};
      out_valid_q         <= 1'b0;
      out_pc_q            <= '0;
      out_data1_q         <= '0;
      out_data2_q         <= '0;
      out_alu_control_q   <= '0;
      out_rd_q            <= '0;
      out_reg_write_q     <= 1'b0;
      out_is_branch_q     <= 1'b0;
      out_branch_offset_q <= '0;
      out_illegal_q       <= 1'b0;
    end else begin
      rf_q                <= rf_d;
      out_valid_q         <= out_valid_d;
      out_pc_q            <= out_pc_d;
      out_data1_q         <= out_data1_d;
      out_data2_q         <= out_data2_d;
      out_alu_control_q   <= out_alu_control_d;
      out_rd_q            <= out_rd_d;
      out_reg_write_q     <= out_reg_write_d;
      out_is_branch_q     <= out_is_branch_d;
      out_branch_offset_q <= out_branch_offset_d;
      out_illegal_q       <= out_illegal_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_pc            = out_pc_q;
  assign out_data1         = out_data1_q;
  assign out_data2         = out_data2_q;
  assign out_alu_control   = out_alu_control_q;
  assign out_rd            = out_rd_q;
  assign out_reg_write     = out_reg_write_q;
  assign out_is_branch     = out_is_branch_q;
  assign out_branch_offset = out_branch_offset_q;
  assign out_illegal       = out_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vector table through a scoreboard queue, plus stall,
// flush and mid-transfer reset sequences; a BYPASS=0 twin shadows the inputs.
module tb_decode_stage;

  localparam logic [4:0] A_ADD = 5'd0,  A_SUB = 5'd1,  A_SLL = 5'd2;
  localparam logic [4:0] A_SRLI_SRAI = 5'd11, A_LUI = 5'd12, A_AUIPC = 5'd13;
  localparam logic [4:0] A_B_EQUAL = 5'd14, A_B_LTU = 5'd18;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  alu;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic [31:0] off;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    exp_t        e;
    logic [31:0] nb_d1;
    logic [31:0] nb_d2;
  } vec_t;

  logic        clock, reset_n;
  logic        in_valid, in_ready, in_ready_nb;
  logic [31:0] in_instr, in_pc;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, out_ready;
  logic        out_valid, out_reg_write, out_is_branch, out_illegal;
  logic [31:0] out_pc, out_data1, out_data2, out_branch_offset;
  logic [4:0]  out_alu_control, out_rd;
  logic        nb_valid, nb_reg_write, nb_is_branch, nb_illegal;
  logic [31:0] nb_pc, nb_data1, nb_data2, nb_branch_offset;
  logic [4:0]  nb_alu_control, nb_rd;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t vecs[16];
  exp_t hold_a, exp_b;

  decode_stage #(.BYPASS(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_data1(out_data1), .out_data2(out_data2), .out_alu_control(out_alu_control),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_is_branch(out_is_branch),
    .out_branch_offset(out_branch_offset), .out_illegal(out_illegal)
  );

  decode_stage #(.BYPASS(0)) dut_nb (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready_nb), .in_instr(in_instr), .in_pc(in_pc),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(nb_valid), .out_ready(out_ready), .out_pc(nb_pc),
    .out_data1(nb_data1), .out_data2(nb_data2), .out_alu_control(nb_alu_control),
    .out_rd(nb_rd), .out_reg_write(nb_reg_write), .out_is_branch(nb_is_branch),
    .out_branch_offset(nb_branch_offset), .out_illegal(nb_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [31:0] pc, d1, d2, input logic [4:0] alu, rd,
                              input logic rw, br, input logic [31:0] off, input logic ill);
    exp_t e;
    e = '{pc: pc, d1: d1, d2: d2, alu: alu, rd: rd, rw: rw, br: br, off: off, ill: ill};
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a = {out_pc, out_data1, out_data2, out_alu_control, out_rd, out_reg_write,
         out_is_branch, out_branch_offset, out_illegal};
    return a;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
  endtask

  task automatic check_word(input string name, input exp_t act, input exp_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic pop_compare(input string name);
    exp_t e;
    check_bit({name, " valid"}, out_valid, 1'b1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got output with empty scoreboard want queued entry", name);
    end else begin
      e = exp_q.pop_front();
      check_word(name, actual(), e);
    end
  endtask

  task automatic drive(input logic [31:0] instr, pc, input logic v, rdy, fl);
    in_instr  = instr;
    in_pc     = pc;
    in_valid  = v;
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    vecs[0]  = '{32'h002081B3, 32'h100, 0, 0, 0, mk(32'h100, 0, 0, A_ADD, 3, 1, 0, 0, 0), 0, 0};
    vecs[1]  = '{32'h00500093, 32'h104, 0, 0, 0, mk(32'h104, 0, 5, A_ADD, 1, 1, 0, 0, 0), 0, 5};
    vecs[2]  = '{32'h001081B3, 32'h108, 1, 1, 32'h1234,
                 mk(32'h108, 32'h1234, 32'h1234, A_ADD, 3, 1, 0, 0, 0), 0, 0};
    vecs[3]  = '{32'h401082B3, 32'h10C, 1, 2, 32'hDEADBEEF,
                 mk(32'h10C, 32'h1234, 32'h1234, A_SUB, 5, 1, 0, 0, 0), 32'h1234, 32'h1234};
    vecs[4]  = '{32'hFE208CE3, 32'h110, 0, 0, 0,
                 mk(32'h110, 32'h1234, 32'hDEADBEEF, A_B_EQUAL, 0, 0, 1, 32'hFFFFFFF8, 0),
                 32'h1234, 32'hDEADBEEF};
    vecs[5]  = '{32'h40415313, 32'h114, 0, 0, 0,
                 mk(32'h114, 32'hDEADBEEF, 32'h404, A_SRLI_SRAI, 6, 1, 0, 0, 0), 32'hDEADBEEF, 32'h404};
    vecs[6]  = '{32'hFFF00393, 32'h118, 0, 0, 0,
                 mk(32'h118, 0, 32'hFFFFFFFF, A_ADD, 7, 1, 0, 0, 0), 0, 32'hFFFFFFFF};
    vecs[7]  = '{32'h12345437, 32'h11C, 0, 0, 0,
                 mk(32'h11C, 0, 32'h12345000, A_LUI, 8, 1, 0, 0, 0), 0, 32'h12345000};
    vecs[8]  = '{32'hABCDE497, 32'h00001000, 0, 0, 0,
                 mk(32'h1000, 0, 32'hABCDE000, A_AUIPC, 9, 1, 0, 0, 0), 0, 32'hABCDE000};
    vecs[9]  = '{32'h00116863, 32'h124, 0, 0, 0,
                 mk(32'h124, 32'hDEADBEEF, 32'h1234, A_B_LTU, 0, 0, 1, 32'h10, 0),
                 32'hDEADBEEF, 32'h1234};
    vecs[10] = '{32'h00209533, 32'h128, 0, 0, 0,
                 mk(32'h128, 32'h1234, 32'hDEADBEEF, A_SLL, 10, 1, 0, 0, 0), 32'h1234, 32'hDEADBEEF};
    vecs[11] = '{32'h00208033, 32'h12C, 0, 0, 0,
                 mk(32'h12C, 32'h1234, 32'hDEADBEEF, A_ADD, 0, 0, 0, 0, 0), 32'h1234, 32'hDEADBEEF};
    vecs[12] = '{32'h00000000, 32'h130, 0, 0, 0, mk(32'h130, 0, 0, A_ADD, 0, 0, 0, 0, 1), 0, 0};
    vecs[13] = '{32'h02208133, 32'h134, 1, 0, 32'hFFFF, mk(32'h134, 0, 0, A_ADD, 0, 0, 0, 0, 1), 0, 0};
    vecs[14] = '{32'h000005B3, 32'h138, 1, 0, 32'hFFFF, mk(32'h138, 0, 0, A_ADD, 11, 1, 0, 0, 0), 0, 0};
    vecs[15] = '{32'h000115E3, 32'h13C, 0, 0, 0,
                 mk(32'h13C, 32'hDEADBEEF, 0, 5'd15, 0, 0, 1, 32'h80A, 0), 32'hDEADBEEF, 0};

    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    wb_en = 0; wb_rd = 0; wb_data = 0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_word("reset_outputs", actual(), '0);
    check_bit("reset_valid", out_valid, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);
    check_bit("ready_after_reset", in_ready, 1'b1);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].instr, vecs[i].pc, 1, 1, 0);
      wb_en = vecs[i].wb_en; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_data;
      #1;
      check_bit($sformatf("vec%0d in_ready", i), in_ready, 1'b1);
      exp_q.push_back(vecs[i].e);
      @(posedge clock); #1;
      pop_compare($sformatf("vec%0d", i));
      check_word($sformatf("vec%0d nobypass", i), {nb_data1, nb_data2, 77'b0},
                 {vecs[i].nb_d1, vecs[i].nb_d2, 77'b0});
      @(negedge clock);
      wb_en = 0;
    end

    drive(0, 0, 0, 1, 0);
    @(posedge clock); #1;
    check_bit("drain_valid", out_valid, 1'b0);

    // stall: A held for two cycles while B waits
    @(negedge clock);
    hold_a = mk(32'h200, 32'h1234, 5, A_ADD, 1, 1, 0, 0, 0);
    drive(32'h00508093, 32'h200, 1, 0, 0);
    exp_q.push_back(hold_a);
    @(posedge clock); #1;
    pop_compare("stall_a");
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      drive(32'h12345437, 32'h204, 1, 0, 0);
      #1 check_bit($sformatf("stall%0d in_ready", c), in_ready, 1'b0);
      @(posedge clock); #1;
      check_bit($sformatf("stall%0d valid", c), out_valid, 1'b1);
      check_word($sformatf("stall%0d hold", c), actual(), hold_a);
    end
    @(negedge clock);
    out_ready = 1;
    #1 check_bit("release in_ready", in_ready, 1'b1);
    exp_b = mk(32'h204, 0, 32'h12345000, A_LUI, 8, 1, 0, 0, 0);
    exp_q.push_back(exp_b);
    @(posedge clock); #1;
    pop_compare("stall_b");

    // flush with a pending output and a presented instruction; writeback still lands
    @(negedge clock);
    drive(32'h00500093, 32'h208, 1, 0, 1);
    wb_en = 1; wb_rd = 4; wb_data = 32'h55;
    #1 check_bit("flush in_ready", in_ready, 1'b0);
    @(posedge clock); #1;
    check_bit("flush valid", out_valid, 1'b0);
    @(negedge clock);
    drive(0, 0, 0, 1, 0);
    wb_en = 0;
    @(posedge clock); #1;
    check_bit("flush dropped", out_valid, 1'b0);
    @(negedge clock);
    drive(32'h00020633, 32'h20C, 1, 1, 0);
    exp_q.push_back(mk(32'h20C, 32'h55, 0, A_ADD, 12, 1, 0, 0, 0));
    @(posedge clock); #1;
    pop_compare("wb_during_flush");

    // reset while an output is held
    @(negedge clock);
    drive(0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check_bit("midreset valid", out_valid, 1'b0);
    check_word("midreset outputs", actual(), '0);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1;
    repeat (2) begin
      @(posedge clock); #1;
      check_bit("post_reset valid", out_valid, 1'b0);
    end
    @(negedge clock);
    drive(32'h002081B3, 32'h300, 1, 1, 0);
    exp_q.push_back(mk(32'h300, 0, 0, A_ADD, 3, 1, 0, 0, 0));
    @(posedge clock); #1;
    pop_compare("regs_cleared");
    check_bit("scoreboard empty", exp_q.size() == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
